timer_scheduler: RTL and testbench

- Shares one down-counting delay timer among N_REQ requesters, such as drop-animation step, turn timeout, win-flash blink and input debounce.
- Each requester raises a level request with a cycle count.
- The block arbitrates round-robin, loads the count, runs the timer and pulses a one-cycle done back to the owner.
- Sits between the game FSM/display logic and the shared delay resource.

---
 rtl/timer_scheduler.sv | 125 ++++++++++++
 tb/tb_timer_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_scheduler.sv
// Shared down-counting delay timer: round-robin arbitration among N_REQ
// level requesters, one-cycle gnt on load and one-cycle done on expiry.
module timer_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] value,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [OW-1:0]          owner,
  output logic [WIDTH-1:0]       remaining
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [OW-1:0]    pick;
  logic [OW-1:0]    cand;

  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] i);
    if (int'(i) == N_REQ - 1) return '0;
    return i + OW'(1);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First set request at or after the pointer, wrapping at N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      cand = OW'((int'(ptr_q) + j) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    rem_d   = rem_q;
    gnt_d   = '0;
    done_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_COUNT;
          owner_d = pick;
          rem_d   = value[int'(pick)*WIDTH +: WIDTH];
          gnt_d   = onehot(pick);
        end
      end
      ST_COUNT: begin
        // A dropped request takes priority over expiry in the same cycle.
        if (!req[owner_q]) begin
          state_d = ST_IDLE;
          ptr_d   = wrap_inc(owner_q);
          rem_d   = '0;
        end else if (rem_q == '0) begin
          state_d = ST_DONE;
          ptr_d   = wrap_inc(owner_q);
          done_d  = onehot(owner_q);
        end else begin
          rem_d = rem_q - WIDTH'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      rem_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      rem_q   <= rem_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: directed scenarios plus randomized requesters,
// checked every cycle against a time-stamp based reference model.
module tb_timer_scheduler;
  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int OW    = 2;

  logic                   clk = 1'b0;
  logic                   RST;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] value;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [OW-1:0]          owner;
  logic [WIDTH-1:0]       remaining;

  always #5 clk = ~clk;

  timer_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .RST(RST), .req(req), .value(value),
    .gnt(gnt), .done(done), .busy(busy), .owner(owner), .remaining(remaining)
  );

  int     n_chk = 0;
  int     n_err = 0;
  longint cyc   = 0;
  logic [N_REQ-1:0] keep;

  // Reference model: a grant is a time stamp plus a delay; expiry is the
  // cycle gcyc+val+1, remaining is the distance to gcyc+val.
  bit               m_active, m_turn, m_busy;
  longint           m_gcyc, m_val;
  int               m_owner, m_ptr;
  logic [N_REQ-1:0] m_gnt, m_done;
  longint           m_rem;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_turn = 0; m_busy = 0;
    m_gcyc = 0; m_val = 0; m_owner = 0; m_ptr = 0;
    m_gnt = '0; m_done = '0; m_rem = 0;
  endtask

  task automatic model_update();
    cyc++;
    m_gnt  = '0;
    m_done = '0;
    if (RST !== 1'b1) begin
      model_reset();
      return;
    end
    if (m_turn) begin
      m_turn = 0;
      m_busy = 0;
    end else if (m_active) begin
      if (!req[m_owner]) begin
        m_active = 0; m_busy = 0; m_rem = 0;
        m_ptr = (m_owner + 1) % N_REQ;
      end else if (cyc == m_gcyc + m_val + 1) begin
        m_active = 0; m_turn = 1; m_rem = 0;
        m_done[m_owner] = 1'b1;
        m_ptr = (m_owner + 1) % N_REQ;
      end else begin
        m_rem = m_gcyc + m_val - cyc;
      end
    end else begin
      for (int j = 0; j < N_REQ; j++) begin
        int i;
        i = (m_ptr + j) % N_REQ;
        if (req[i]) begin
          m_active = 1; m_busy = 1; m_owner = i; m_gcyc = cyc;
          m_val = longint'(value[i*WIDTH +: WIDTH]);
          m_rem = m_val;
          m_gnt[i] = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("gnt", gnt, m_gnt);
    chk("done", done, m_done);
    chk("busy", busy, m_busy);
    chk("owner", owner, m_owner);
    chk("remaining", remaining, m_rem);
    chk("gnt_done_excl", (gnt != 0) && (done != 0), 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
    for (int i = 0; i < N_REQ; i++)
      if (m_done[i] && !keep[i]) req[i] = 1'b0;
  endtask

  task automatic wait_gnt(input int idx, input int bound);
    int n;
    n = 0;
    while (!m_gnt[idx] && n < bound) begin
      step();
      n++;
    end
    chk("wait_gnt", m_gnt[idx], 1);
  endtask

  // Off-edge asynchronous reset; outputs must clear before any clock edge.
  task automatic async_reset();
    #2 RST = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_remaining", remaining, 0);
    model_reset();
    @(negedge clk);
    RST = 1'b1;
  endtask

  task automatic set_val(input int i, input longint v);
    value[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    longint g, d;
    RST = 1'b0; req = '0; value = '0; keep = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();

    // Single delay of 3
    set_val(0, 3); req = 4'b0001; RST = 1'b1;
    repeat (9) step();

    // Zero delay on requester 2
    set_val(2, 0); req = 4'b0100;
    repeat (5) step();

    // Round-robin among 0,1,3 held continuously from reset
    async_reset();
    set_val(0, 1); set_val(1, 1); set_val(3, 1);
    keep = 4'b1011; req = 4'b1011;
    repeat (16) step();
    req = '0; keep = '0;
    repeat (3) step();

    // Pointer wrap: serve 2, then 3 wins over 1
    set_val(2, 0); req = 4'b0100;
    wait_gnt(2, 10);
    set_val(1, 1); set_val(3, 2); req[1] = 1'b1; req[3] = 1'b1;
    repeat (14) step();

    // Cancel with a pending request behind it
    set_val(1, 10); req = 4'b0010;
    wait_gnt(1, 10);
    set_val(2, 2); req[2] = 1'b1;
    repeat (3) step();
    req[1] = 1'b0;
    repeat (8) step();

    // Reset mid-count, then the full 20-cycle delay from a fresh grant
    set_val(0, 20); req = 4'b0001;
    wait_gnt(0, 10);
    repeat (5) step();
    async_reset();
    g = -1; d = -1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (gnt[0] === 1'b1) g = cyc;
      if (done[0] === 1'b1) begin
        d = cyc;
        break;
      end
    end
    chk("latency_20", d - g, 21);
    repeat (3) step();

    // Randomized requesters
    req = '0;
    for (int n = 0; n < 3000; n++) begin
      keep = N_REQ'($urandom);
      for (int i = 0; i < N_REQ; i++) begin
        if ($urandom_range(0, 7) == 0)
          set_val(i, ($urandom_range(0, 15) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6));
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 40) == 0) req[i] = 1'b0;
      end
      if ($urandom_range(0, 499) == 0) async_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
